// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO.
// The line is sampled at mid-bit through a 2-flop synchroniser; received bytes queue for fabric logic.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rxd,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] count,
    output logic          frame_err,
    output logic          overrun
);

    // state   | meaning
    // S_IDLE  | line idle, waiting for a falling edge on rxs
    // S_START | timing to the middle of the start bit to confirm it
    // S_DATA  | sampling 8 data bits LSB-first, one per DIV cycles
    // S_STOP  | sampling the stop bit; high pushes the byte, low flags frame_err
    // S_BREAK | line held low after a framing error, waiting for idle
    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int DW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(HALF - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rxs;
    logic [DW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [7:0]      rx_byte;
    logic            push_req;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   occ;
    logic            full;
    logic            pop;
    logic            push_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rxs) state <= S_START;
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            rx_byte  <= shreg;
                            push_req <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    cnt <= '0;
                    if (rxs) state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push.
    assign full    = (occ == FULL_CNT);
    assign pop     = rd_en && rd_valid;
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push_req && full && !pop;
            if (push_ok) begin
                mem[wr_ptr] <= rx_byte;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop) occ <= occ + 1'b1;
            else if (pop && !push_ok) occ <= occ - 1'b1;
        end
    end

    assign count    = occ;
    assign rd_valid = (occ != '0);
    assign rd_data  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a byte-queue model predicts FIFO contents and flag counts.
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 50000000;
    localparam int BAUD   = 3125000;
    localparam int DEPTH  = 16;
    localparam int CW     = 5;
    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF   = DIV / 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rxd;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overrun;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rstn(rstn), .rxd(rxd), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .count(count), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    int exp_ferr = 0, exp_ovr = 0;
    int obs_ferr = 0, obs_ovr = 0;
    logic prev_ferr = 1'b0, prev_ovr = 1'b0;
    int last_pop = -1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp_v, exp_v, $time);
        end
    endtask

    // Monitor: every accepted pop is checked against the model head; flag pulses are tallied.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (rd_en && rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_data: popped 0x%02h, model queue empty", rd_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("pop_data", int'(rd_data), int'(e));
                    last_pop = int'(rd_data);
                end
            end
            if (frame_err) obs_ferr++;
            if (overrun) obs_ovr++;
            if (frame_err || overrun)
                chk("flag_excl_single", int'({frame_err & overrun, frame_err & prev_ferr, overrun & prev_ovr}), 0);
        end
        prev_ferr = frame_err;
        prev_ovr  = overrun;
    end

    // All tasks start and end one time unit after a rising edge.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        rxd = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rxd = stop_ok;
        repeat (DIV) @(posedge clk);
        #1;
        if (stop_ok) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovr++;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("drain_valid", int'(rd_valid), 1);
            pop_one();
        end
        chk("drain_empty_count", int'(count), 0);
        chk("drain_empty_valid", int'(rd_valid), 0);
    endtask

    task automatic check_flags(input string name);
        chk({name, "_ferr"}, obs_ferr, exp_ferr);
        chk({name, "_ovr"}, obs_ovr, exp_ovr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovr_base;
        rstn  = 1'b0;
        rxd   = 1'b1;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_flags", int'({frame_err, overrun}), 0);
        rstn = 1'b1;
        idle(4);

        // single byte
        send_frame(8'hA5, 1'b1);
        chk("t1_valid", int'(rd_valid), 1);
        chk("t1_data", int'(rd_data), 8'hA5);
        chk("t1_count", int'(count), 1);
        pop_one();
        chk("t1_valid_after_pop", int'(rd_valid), 0);
        chk("t1_count_after_pop", int'(count), 0);

        // back-to-back frames
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        chk("t2_count", int'(count), 3);
        drain();
        check_flags("t2");

        // short start glitch is rejected
        rxd = 1'b0;
        idle(HALF - 3);
        rxd = 1'b1;
        idle(3 * DIV);
        chk("t3_count", int'(count), 0);
        check_flags("t3");

        // framing error followed by a long break
        send_frame(8'h3C, 1'b0);
        idle(5000);
        rxd = 1'b1;
        idle(2 * DIV);
        chk("t4_count", int'(count), 0);
        chk("t4_one_ferr", obs_ferr, 1);
        check_flags("t4");
        send_frame(8'h3C, 1'b1);
        chk("t4_data", int'(rd_data), 8'h3C);
        drain();

        // overflow: 17th byte dropped
        ovr_base = obs_ovr;
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b1);
        chk("t5_count_full", int'(count), DEPTH);
        chk("t5_one_ovr", obs_ovr - ovr_base, 1);
        check_flags("t5a");
        drain();

        // overflow with pop in the push cycle of the 17th byte
        ovr_base = obs_ovr;
        for (int i = 1; i <= 16; i++) send_frame(8'(i), 1'b1);
        fork
            send_frame(8'h11, 1'b1);
            begin
                repeat (3 + HALF + 9 * DIV) @(posedge clk);
                #1;
                rd_en = 1'b1;
                @(posedge clk);
                #1;
                rd_en = 1'b0;
            end
        join
        chk("t5b_count", int'(count), DEPTH);
        chk("t5b_no_ovr", obs_ovr - ovr_base, 0);
        drain();
        chk("t5b_last", last_pop, 8'h11);
        check_flags("t5b");

        // randomized traffic
        for (int k = 0; k < 24; k++) begin
            idle($urandom_range(0, 12));
            send_frame(8'($urandom), 1'b1);
            if ($urandom_range(0, 2) != 0) pop_one();
        end
        chk("rand_count", int'(count), exp_q.size());
        drain();
        check_flags("rand");

        // reset during DATA discards everything
        send_frame(8'h42, 1'b1);
        rxd = 1'b0;
        idle(DIV);
        rxd = 1'b1;
        idle(3 * DIV + 5);
        #2;
        rstn = 1'b0;
        rxd  = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rd_data", int'(rd_data), 0);
        chk("t6_rd_valid", int'(rd_valid), 0);
        chk("t6_count", int'(count), 0);
        chk("t6_flags", int'({frame_err, overrun}), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(3 * DIV);
        chk("t6_count_idle", int'(count), 0);
        send_frame(8'h7E, 1'b1);
        chk("t6_data", int'(rd_data), 8'h7E);
        chk("t6_count_one", int'(count), 1);
        drain();
        check_flags("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Fabric-side UART receiver with a byte FIFO. It forms the far end of the SoC UART2 link: it deserialises the 8N1 stream the AE350 drives on UART2_TXD and buffers the bytes for fabric logic such as a loopback checker or an LED/status decoder. It runs on the 50 MHz board clock and is reset by the debounced board reset.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
BAUD, 115200, line rate in bit/s; DIV = round(CLK_HZ/BAUD) = 434 at defaults; HALF = DIV/2 (integer, 217)
FIFO_DEPTH, 16, FIFO entries; must be a power of 2, >= 2
CW, 5, count width = log2(FIFO_DEPTH)+1

Ports:
clk  input  1  board clock (50 MHz)
rstn  input  1  asynchronous active-low reset
rxd  input  1  serial input, idle high, asynchronous to clk
rd_en  input  1  pop request; honoured only when rd_valid=1
rd_data  output  8  FIFO head byte (first-word-fall-through), valid when rd_valid=1
rd_valid  output  1  FIFO not empty
count  output  CW  FIFO occupancy, 0..FIFO_DEPTH
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: received byte dropped because the FIFO was full

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rstn). All state clears on rstn=0 regardless of activity: rd_data=0x00, rd_valid=0, count=0, frame_err=0, overrun=0, FSM=IDLE, synchroniser flops=1, bit counter and divider=0. A frame in progress at reset is discarded.
- Input sync: rxd passes through a 2-flop synchroniser (rxs); all decoding uses rxs. Input-to-rxs latency is 2 cycles.
- Divider: counter cnt, reloads to 0 on every FSM transition and on every sample.
- FSM states and transitions:
  - IDLE: if rxs=0, go to START with cnt=0.
  - START: when cnt=HALF-1, sample rxs. 0 -> DATA with bit index=0 and cnt=0. 1 -> IDLE (glitch rejected, no flag).
  - DATA: when cnt=DIV-1, shift rxs in LSB-first. After bit 7 -> STOP.
  - STOP: when cnt=DIV-1, sample rxs.
    - 1 -> push the byte (see FIFO rules), then IDLE.
    - 0 -> frame_err pulse, byte discarded, then BREAK.
  - BREAK: wait for rxs=1, then IDLE. A held-low line (break) produces exactly one frame_err.
- Sample points sit at mid-bit: start at HALF, each later bit DIV after the previous sample.
- FIFO: FWFT circular buffer with rd/wr pointers of log2(FIFO_DEPTH) bits. Pointers wrap naturally. count tracks occupancy.
  - Push occurs in the cycle after the valid stop sample. rd_valid/rd_data/count update in the following cycle, i.e. 2 cycles after the stop sample.
  - Pop: rd_en=1 and rd_valid=1 advances rd ptr. The next head is visible the next cycle. rd_en with rd_valid=0 is ignored.
  - Push when count=FIFO_DEPTH and no pop in the same cycle: byte dropped, overrun pulses for 1 cycle, contents unchanged.
  - Push and pop in the same cycle when full: both accepted, count unchanged, no overrun.
  - Push and pop in the same cycle when non-empty and not full: count unchanged.
  - Push when empty: rd_valid rises. A simultaneous rd_en is ignored because it arrived while empty.
- frame_err and overrun are mutually exclusive per frame and never held longer than 1 cycle.
- No parity; exactly 1 stop bit is checked. Back-to-back frames are supported: a new start edge is accepted in the first IDLE cycle after STOP.

Test Plan:
1. Reset, then send 0xA5 at 115200 (434 clk/bit) -> after the stop sample, rd_valid=1, rd_data=0xA5, count=1. Pulse rd_en -> rd_valid=0, count=0.
2. Send back-to-back 0x00, 0xFF, 0x55 with no idle gap and do not read -> count=3. Pops return 0x00, 0xFF, 0x55 in order. No frame_err or overrun.
3. Low glitch of 100 cycles on rxd -> START aborts to IDLE, count stays 0, no flags.
4. Frame 0x3C with the stop bit forced low, rxd held low for 5000 cycles -> exactly one frame_err pulse, count=0. Then release and send 0x3C -> received correctly.
5. Send 17 bytes 0x01..0x11 without reading -> count=16, one overrun pulse on byte 0x11. Drain yields 0x01..0x10. Repeat with rd_en asserted in the push cycle of the 17th byte -> no overrun, last entry 0x11.
6. Assert rstn=0 mid-DATA of a frame and release -> all outputs 0. The partial frame is not stored, and the next full frame 0x7E is received correctly.
